// File: rtl/mem_access.sv
// mem_access: data-memory access stage of the in-order pipeline.
//
// Decodes the memory op from the EX/MEM register. Loads and stores run a
// req/ack transaction on the data bus, with byte enables and lane steering.
// Load data is sign- or zero-extended. The writeback triple is forwarded
// toward WB through an output register. Upstream is stalled while a bus
// transaction is outstanding.
//
// Ports
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   mem_op_i                       0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU,
//                                  6 SB, 7 SH, 8 SW, others NOP
//   mem_we_i                       store flag (unused, the op decides)
//   mem_addr_i, mem_data_i         byte address, store data
//   reg_waddr_i/we_i/wdata_i       writeback triple from EX
//   dbus_*                         data bus (req held until one-cycle ack)
//   stall_o                        combinational upstream hold
//   misalign_o                     one-cycle pulse on a misaligned access
//   reg_waddr_o/we_o/wdata_o       writeback triple to WB
module mem_access #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [3:0]             mem_op_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
  output logic [3:0]             dbus_be_o,
  output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
  input  logic                   dbus_ack_i,
  input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
  output logic                   stall_o,
  output logic                   misalign_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [DATA_WIDTH-1:0]  reg_wdata_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t state, state_nxt;

  // The store flag is redundant with the op encoding.
  logic unused_we;
  assign unused_we = mem_we_i;

  function automatic logic [3:0] byte_enables(input logic [3:0] op, input logic [1:0] lane);
    case (op)
      OP_LB, OP_LBU, OP_SB: byte_enables = 4'b0001 << lane;
      OP_LH, OP_LHU, OP_SH: byte_enables = lane[1] ? 4'b1100 : 4'b0011;
      default:              byte_enables = 4'b1111;
    endcase
  endfunction

  // Replicate the store value across lanes so the enabled lanes carry it.
  function automatic logic [DATA_WIDTH-1:0] steer_store(input logic [3:0] op,
                                                        input logic [DATA_WIDTH-1:0] data);
    case (op)
      OP_SB:   steer_store = {4{data[7:0]}};
      OP_SH:   steer_store = {2{data[15:0]}};
      default: steer_store = data;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] format_load(input logic [3:0] op,
                                                        input logic [1:0] lane,
                                                        input logic [DATA_WIDTH-1:0] rdata);
    logic [DATA_WIDTH-1:0] shifted;
    shifted = rdata >> {lane, 3'b000};
    case (op)
      OP_LB:   format_load = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      OP_LH:   format_load = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      OP_LBU:  format_load = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      OP_LHU:  format_load = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: format_load = shifted;
    endcase
  endfunction

  // Decode of the presented instruction
  logic is_load, is_store, is_access, is_misaligned, start_access;

  always_comb begin
    is_load   = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LHU);
    is_store  = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    is_access = is_load || is_store;
    case (mem_op_i)
      OP_LH, OP_LHU, OP_SH: is_misaligned = mem_addr_i[0];
      OP_LW, OP_SW:         is_misaligned = (mem_addr_i[1:0] != 2'b00);
      default:              is_misaligned = 1'b0;
    endcase
    start_access = (state == IDLE) && is_access && !is_misaligned;
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_access) state_nxt = BUS;
      BUS:     if (dbus_ack_i)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dbus_req_o = (state == BUS);
    stall_o    = start_access || (state == BUS);
  end

  // Stage p1: bus request registers, stable for the whole transaction
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic [3:0]            be_p1;
  logic                  we_p1;
  logic [3:0]            op_p1;
  logic [1:0]            lane_p1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_p1  <= '0;
      wdata_p1 <= '0;
      be_p1    <= '0;
      we_p1    <= 1'b0;
      op_p1    <= '0;
      lane_p1  <= '0;
    end else if (start_access) begin
      addr_p1  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
      wdata_p1 <= steer_store(mem_op_i, mem_data_i);
      be_p1    <= byte_enables(mem_op_i, mem_addr_i[1:0]);
      we_p1    <= is_store;
      op_p1    <= mem_op_i;
      lane_p1  <= mem_addr_i[1:0];
    end
  end

  assign dbus_addr_o  = addr_p1;
  assign dbus_wdata_o = wdata_p1;
  assign dbus_be_o    = be_p1;
  assign dbus_we_o    = we_p1;

  // Stage p2: load hold register, captured on the acknowledged bus cycle
  logic [DATA_WIDTH-1:0] hold_p2;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                          hold_p2 <= '0;
    else if ((state == BUS) && dbus_ack_i) hold_p2 <= format_load(op_p1, lane_p1, dbus_rdata_i);
  end

  // Stage p3: writeback output register; carries a bubble while accessing
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      reg_waddr_o <= '0;
      reg_we_o    <= 1'b0;
      reg_wdata_o <= '0;
      misalign_o  <= 1'b0;
    end else begin
      reg_waddr_o <= '0;
      reg_we_o    <= 1'b0;
      reg_wdata_o <= '0;
      misalign_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_access) begin
            reg_waddr_o <= reg_waddr_i;
            reg_we_o    <= reg_we_i;
            reg_wdata_o <= reg_wdata_i;
          end
          misalign_o <= is_access && is_misaligned;
        end
        DONE: begin
          reg_waddr_o <= reg_waddr_i;
          reg_we_o    <= reg_we_i;
          reg_wdata_o <= we_p1 ? reg_wdata_i : hold_p2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios followed by a
// randomized instruction stream, each instruction checked cycle by cycle
// against a transaction-level reference model.
module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  mem_op_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [4:0]  reg_waddr_i;
  logic        reg_we_i;
  logic [31:0] reg_wdata_i;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_ack_i;
  logic [31:0] dbus_rdata_i;
  logic        stall_o;
  logic        misalign_o;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;
  logic [31:0] reg_wdata_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_access dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mem_op_i(mem_op_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
    .stall_o(stall_o), .misalign_o(misalign_o),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, stated directly in terms of access size and byte lanes.
  function automatic int op_bytes(input logic [3:0] op);
    if (op == 1 || op == 4 || op == 6) return 1;
    if (op == 2 || op == 5 || op == 7) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] op, input int a);
    int n = op_bytes(op);
    if (n == 1) return 4'(1 << a);
    if (n == 2) return (a >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] op, input logic [31:0] d);
    if (op == 6) return (d % 256) * 32'h0101_0101;
    if (op == 7) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op, input int a, input logic [31:0] rd);
    logic [31:0] w, v;
    w = rd / (32'd1 << (8 * a));
    case (op)
      1, 4:    v = w % 256;
      2, 5:    v = w % 65536;
      default: v = w;
    endcase
    if (op == 1 && v >= 128)   v = v - 32'd256;
    if (op == 2 && v >= 32768) v = v - 32'd65536;
    return v;
  endfunction

  // Called at a falling edge; presents one instruction, plays the bus with
  // k wait states and returns at the falling edge where the next
  // instruction may be presented.
  task automatic exec(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                      input logic [4:0] wa, input logic rwe, input logic [31:0] rwd,
                      input int k, input logic [31:0] rdata);
    bit acc, ld, mis;
    int a;
    acc = (op >= 1 && op <= 8);
    ld  = (op >= 1 && op <= 5);
    a   = int'(addr % 4);
    mis = acc && ((addr % op_bytes(op)) != 0);
    mem_op_i = op; mem_we_i = acc && !ld; mem_addr_i = addr; mem_data_i = sdata;
    reg_waddr_i = wa; reg_we_i = rwe; reg_wdata_i = rwd; dbus_ack_i = 1'b0;
    #1;
    check_val("stall_present", stall_o, acc && !mis);
    check_val("req_present", dbus_req_o, 0);
    if (!acc || mis) begin
      @(negedge clk_i);
      check_val("req_none", dbus_req_o, 0);
      check_val("misalign", misalign_o, mis);
      check_val("waddr_o", reg_waddr_o, mis ? 0 : wa);
      check_val("we_o", reg_we_o, mis ? 0 : rwe);
      check_val("wdata_o", reg_wdata_o, mis ? 0 : rwd);
    end else begin
      for (int i = 0; i <= k; i++) begin
        @(negedge clk_i);
        check_val("req_bus", dbus_req_o, 1);
        check_val("stall_bus", stall_o, 1);
        check_val("bus_we", dbus_we_o, !ld);
        check_val("bus_addr", dbus_addr_o, addr - a);
        check_val("bus_be", dbus_be_o, model_be(op, a));
        if (!ld) check_val("bus_wdata", dbus_wdata_o, model_wdata(op, sdata));
        check_val("bubble_bus", reg_we_o, 0);
        check_val("misalign_bus", misalign_o, 0);
        dbus_ack_i   = (i == k);
        dbus_rdata_i = (i == k) ? rdata : $urandom;
      end
      @(negedge clk_i);
      dbus_ack_i = 1'b0;
      dbus_rdata_i = $urandom;
      #1;
      check_val("req_done", dbus_req_o, 0);
      check_val("stall_done", stall_o, 0);
      check_val("bubble_done", reg_we_o, 0);
      @(negedge clk_i);
      check_val("waddr_acc", reg_waddr_o, wa);
      check_val("we_acc", reg_we_o, rwe);
      check_val("wdata_acc", reg_wdata_o, ld ? model_load(op, a, rdata) : rwd);
    end
  endtask

  initial begin
    rst_ni = 1'b0; mem_op_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_data_i = 0;
    reg_waddr_i = 0; reg_we_i = 0; reg_wdata_i = 0; dbus_ack_i = 0; dbus_rdata_i = 0;
    repeat (2) @(negedge clk_i);
    check_val("rst_req", dbus_req_o, 0);
    check_val("rst_misalign", misalign_o, 0);
    check_val("rst_we", reg_we_o, 0);
    check_val("rst_wdata", reg_wdata_o, 0);
    check_val("rst_stall", stall_o, 0);
    rst_ni = 1'b1;

    exec(4'd0, 32'h100, 32'h0, 5'd3, 1'b1, 32'h5, 0, 32'h0);            // NOP / ADDI pass-through
    exec(4'd1, 32'h1003, 32'h0, 5'd4, 1'b1, 32'h0, 0, 32'h80FF_FFFF);   // LB
    check_val("lb_value", reg_wdata_o, 32'hFFFF_FF80);
    exec(4'd4, 32'h1003, 32'h0, 5'd4, 1'b1, 32'h0, 0, 32'h80FF_FFFF);   // LBU
    check_val("lbu_value", reg_wdata_o, 32'h0000_0080);
    exec(4'd7, 32'h2002, 32'h1234_ABCD, 5'd0, 1'b0, 32'h0, 3, 32'h0);   // SH, 3 waits
    exec(4'd3, 32'h3001, 32'h0, 5'd9, 1'b1, 32'h99, 0, 32'h0);          // misaligned LW
    exec(4'd8, 32'h10, 32'h0BAD_F00D, 5'd0, 1'b0, 32'h0, 1, 32'h0);     // SW
    exec(4'd3, 32'h10, 32'h0, 5'd6, 1'b1, 32'h0, 0, 32'hDEAD_BEEF);     // LW
    check_val("lw_value", reg_wdata_o, 32'hDEAD_BEEF);

    // LHU abandoned by reset in its second bus cycle; a later ack is ignored.
    mem_op_i = 4'd5; mem_addr_i = 32'h4002; reg_waddr_i = 5'd2; reg_we_i = 1'b1;
    #1 check_val("lhu_stall", stall_o, 1);
    @(negedge clk_i);
    check_val("lhu_req1", dbus_req_o, 1);
    @(negedge clk_i);
    check_val("lhu_req2", dbus_req_o, 1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_val("abort_req", dbus_req_o, 0);
    check_val("abort_we", reg_we_o, 0);
    check_val("abort_wdata", reg_wdata_o, 0);
    check_val("abort_addr", dbus_addr_o, 0);
    check_val("abort_be", dbus_be_o, 0);
    rst_ni = 1'b1; mem_op_i = 4'd0; reg_waddr_i = 5'd7; reg_wdata_i = 32'h77;
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'h1234_5678;
    #1 check_val("late_ack_req", dbus_req_o, 0);
    @(negedge clk_i);
    dbus_ack_i = 1'b0;
    check_val("late_ack_req2", dbus_req_o, 0);
    check_val("late_ack_waddr", reg_waddr_o, 7);
    check_val("late_ack_wdata", reg_wdata_o, 32'h77);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] ad;
      ad = $urandom;
      if ($urandom_range(0, 1) == 0) ad[1:0] = 2'b00;
      exec(4'($urandom_range(0, 15)), ad, $urandom, 5'($urandom), 1'($urandom), $urandom,
           $urandom_range(0, 3), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete (compared %0d)", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
